// File: rtl/ballot_pkg.sv
// Shared definitions for the ballot arbiter: session states, candidate id width
// and default sizing.
package ballot_pkg;

    localparam int CAND_ID_W      = 2;
    localparam int DEF_NUM_BOOTHS = 4;
    localparam int DEF_NUM_CAND   = 3;
    localparam int DEF_CNT_W      = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_OPEN   = 2'b01,
        S_DRAIN  = 2'b10,
        S_RESULT = 2'b11
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping at N. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_grant && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ballot_arbiter.sv
// Election session controller: shares one set of saturating candidate tallies
// between several booths using a round-robin grant and one vote per press.
module ballot_arbiter
    import ballot_pkg::*;
#(
    parameter int NUM_BOOTHS = DEF_NUM_BOOTHS,
    parameter int NUM_CAND   = DEF_NUM_CAND,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_open,
    input  logic                            i_close,
    input  logic [NUM_BOOTHS-1:0]           i_booth_req,
    input  logic [CAND_ID_W*NUM_BOOTHS-1:0] i_booth_cand,
    output logic [NUM_BOOTHS-1:0]           o_booth_ack,
    output logic                            o_invalid,
    output logic [1:0]                      o_state,
    output logic                            o_result_valid,
    output logic [CNT_W*NUM_CAND-1:0]       o_count,
    output logic                            o_overflow
);

    localparam int PTR_W = $clog2(NUM_BOOTHS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                             state;
    logic [NUM_BOOTHS-1:0]              armed;
    logic [PTR_W-1:0]                   ptr;
    logic [NUM_CAND-1:0][CNT_W-1:0]     tally;
    logic [NUM_CAND-1:0][CNT_W-1:0]     result;
    logic [NUM_BOOTHS-1:0]              eligible;
    logic [NUM_BOOTHS-1:0]              grant;
    logic [PTR_W-1:0]                   grant_idx;
    logic                               any_grant;
    logic [CAND_ID_W-1:0]               sel_cand;
    logic                               cand_valid;
    logic [PTR_W-1:0]                   next_ptr;

    // A close in the same cycle suppresses grants so the drain starts clean.
    assign eligible = i_booth_req & armed
                    & {NUM_BOOTHS{(state == S_OPEN) && !i_close}};

    rr_arbiter #(
        .N     (NUM_BOOTHS),
        .IDX_W (PTR_W)
    ) u_rr (
        .req       (eligible),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        sel_cand = '0;
        for (int b = 0; b < NUM_BOOTHS; b++) begin
            if (grant[b]) begin
                sel_cand = i_booth_cand[b*CAND_ID_W +: CAND_ID_W];
            end
        end
        cand_valid = int'(sel_cand) < NUM_CAND;
        next_ptr   = (int'(grant_idx) == NUM_BOOTHS - 1) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            armed       <= '1;
            ptr         <= '0;
            tally       <= '0;
            result      <= '0;
            o_booth_ack <= '0;
            o_invalid   <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_booth_ack <= grant;
            o_invalid   <= any_grant && !cand_valid;
            // A released button re-arms its booth, so a held press counts once.
            armed       <= (armed & ~grant) | ~i_booth_req;
            if (any_grant) begin
                ptr <= next_ptr;
            end
            case (state)
                S_IDLE, S_RESULT: begin
                    if (i_open) begin
                        state      <= S_OPEN;
                        tally      <= '0;
                        o_overflow <= 1'b0;
                    end
                end
                S_OPEN: begin
                    if (i_close) begin
                        state <= S_DRAIN;
                    end else if (any_grant && cand_valid) begin
                        for (int c = 0; c < NUM_CAND; c++) begin
                            if (sel_cand == CAND_ID_W'(c)) begin
                                if (tally[c] == CNT_MAX) begin
                                    o_overflow <= 1'b1;
                                end else begin
                                    tally[c] <= tally[c] + 1'b1;
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    result <= tally;
                    state  <= S_RESULT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_state        = state;
    assign o_result_valid = (state == S_RESULT);
    assign o_count        = (state == S_RESULT) ? result : '0;

endmodule

// File: tb/tb_ballot_arbiter.sv
// Directed bench for ballot_arbiter with hand-computed expectations for
// session sequencing, round-robin order, one-vote-per-press and saturation.
module tb_ballot_arbiter;

    logic        clk;
    logic        rst;
    logic        i_open;
    logic        i_close;
    logic [3:0]  i_booth_req;
    logic [7:0]  i_booth_cand;
    logic [3:0]  o_booth_ack;
    logic        o_invalid;
    logic [1:0]  o_state;
    logic        o_result_valid;
    logic [17:0] o_count;
    logic        o_overflow;

    int total;
    int bad;

    ballot_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_open         (i_open),
        .i_close        (i_close),
        .i_booth_req    (i_booth_req),
        .i_booth_cand   (i_booth_cand),
        .o_booth_ack    (o_booth_ack),
        .o_invalid      (o_invalid),
        .o_state        (o_state),
        .o_result_valid (o_result_valid),
        .o_count        (o_count),
        .o_overflow     (o_overflow)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Drive one cycle of inputs, then let the edge happen and settle 1 time unit.
    task automatic applyStimulus(input logic r, input logic op, input logic cl,
                                 input logic [3:0] req, input logic [7:0] cand);
        rst          = r;
        i_open       = op;
        i_close      = cl;
        i_booth_req  = req;
        i_booth_cand = cand;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; i_open = 1'b0; i_close = 1'b0;
        i_booth_req = '0; i_booth_cand = '0;

        applyStimulus(1, 0, 0, 4'b0000, 8'h00);
        checkOutput("reset_state", 32'(o_state), 0);
        checkOutput("reset_ack", 32'(o_booth_ack), 0);
        checkOutput("reset_count", 32'(o_count), 0);
        checkOutput("reset_valid", 32'(o_result_valid), 0);
        checkOutput("reset_ovf", 32'(o_overflow), 0);

        // Open and close together in IDLE: open wins
        applyStimulus(0, 1, 1, 4'b0000, 8'h00);
        checkOutput("open_wins_idle", 32'(o_state), 1);

        // Booth 0 holds cand 1 for three cycles: exactly one ack
        applyStimulus(0, 0, 0, 4'b0001, 8'b00_00_00_01);
        checkOutput("single_ack", 32'(o_booth_ack), 4'b0001);
        applyStimulus(0, 0, 0, 4'b0001, 8'b00_00_00_01);
        checkOutput("held_no_ack1", 32'(o_booth_ack), 0);
        applyStimulus(0, 0, 0, 4'b0001, 8'b00_00_00_01);
        checkOutput("held_no_ack2", 32'(o_booth_ack), 0);
        applyStimulus(0, 0, 0, 4'b0000, 8'h00);
        applyStimulus(0, 0, 1, 4'b0000, 8'h00);
        checkOutput("drain_state", 32'(o_state), 2);
        checkOutput("drain_count_hidden", 32'(o_count), 0);
        applyStimulus(0, 0, 0, 4'b0000, 8'h00);
        checkOutput("result_state", 32'(o_state), 3);
        checkOutput("result_valid", 32'(o_result_valid), 1);
        checkOutput("result_tally1", 32'(o_count), 32'd1 << 6);

        // Fresh reset puts the pointer at 0; all four booths hold requests
        applyStimulus(1, 0, 0, 4'b0000, 8'h00);
        applyStimulus(0, 1, 0, 4'b0000, 8'h00);
        applyStimulus(0, 0, 0, 4'b1111, 8'b00_10_01_00);
        checkOutput("rr_ack0", 32'(o_booth_ack), 4'b0001);
        applyStimulus(0, 0, 0, 4'b1111, 8'b00_10_01_00);
        checkOutput("rr_ack1", 32'(o_booth_ack), 4'b0010);
        applyStimulus(0, 0, 0, 4'b1111, 8'b00_10_01_00);
        checkOutput("rr_ack2", 32'(o_booth_ack), 4'b0100);
        applyStimulus(0, 0, 0, 4'b1111, 8'b00_10_01_00);
        checkOutput("rr_ack3", 32'(o_booth_ack), 4'b1000);
        applyStimulus(0, 0, 0, 4'b1111, 8'b00_10_01_00);
        checkOutput("rr_no_second", 32'(o_booth_ack), 0);
        applyStimulus(0, 0, 0, 4'b0000, 8'h00);
        applyStimulus(0, 0, 1, 4'b0000, 8'h00);
        applyStimulus(0, 0, 0, 4'b0000, 8'h00);
        checkOutput("rr_tallies", 32'(o_count), {14'd0, 6'd1, 6'd1, 6'd2});

        // Reopen; booth 1 votes cand 0 to move the pointer to 2
        applyStimulus(0, 1, 1, 4'b0000, 8'h00);
        checkOutput("reopen_state", 32'(o_state), 1);
        checkOutput("reopen_count", 32'(o_count), 0);
        applyStimulus(0, 0, 0, 4'b0010, 8'h00);
        checkOutput("ptr_setup_ack", 32'(o_booth_ack), 4'b0010);
        applyStimulus(0, 0, 0, 4'b0000, 8'h00);
        // Pointer 2, booths 1 (cand 0) and 3 (cand 1): booth 3 first
        applyStimulus(0, 0, 0, 4'b1010, 8'b01_00_00_00);
        checkOutput("ptr2_first", 32'(o_booth_ack), 4'b1000);
        applyStimulus(0, 0, 0, 4'b1010, 8'b01_00_00_00);
        checkOutput("ptr2_second", 32'(o_booth_ack), 4'b0010);
        applyStimulus(0, 0, 0, 4'b0000, 8'h00);
        // Booth 2 votes the out-of-range id 3
        applyStimulus(0, 0, 0, 4'b0100, 8'b00_11_00_00);
        checkOutput("invalid_ack", 32'(o_booth_ack), 4'b0100);
        checkOutput("invalid_pulse", 32'(o_invalid), 1);
        applyStimulus(0, 0, 0, 4'b0000, 8'h00);
        checkOutput("invalid_one_cycle", 32'(o_invalid), 0);
        applyStimulus(0, 0, 1, 4'b0000, 8'h00);
        applyStimulus(0, 0, 0, 4'b0000, 8'h00);
        checkOutput("invalid_tallies", 32'(o_count), {14'd0, 6'd0, 6'd1, 6'd2});
        checkOutput("no_ovf_yet", 32'(o_overflow), 0);

        // 63 presses fill tally0; the 64th saturates and flags overflow
        applyStimulus(0, 1, 0, 4'b0000, 8'h00);
        for (int n = 0; n < 63; n++) begin
            applyStimulus(0, 0, 0, 4'b0001, 8'h00);
            applyStimulus(0, 0, 0, 4'b0000, 8'h00);
        end
        checkOutput("ovf_at_63", 32'(o_overflow), 0);
        applyStimulus(0, 0, 0, 4'b0001, 8'h00);
        checkOutput("ovf_64th_ack", 32'(o_booth_ack), 4'b0001);
        checkOutput("ovf_set", 32'(o_overflow), 1);
        applyStimulus(0, 0, 0, 4'b0000, 8'h00);
        applyStimulus(0, 0, 1, 4'b0000, 8'h00);
        applyStimulus(0, 0, 0, 4'b0000, 8'h00);
        checkOutput("sat_tally0", 32'(o_count), 63);
        checkOutput("ovf_sticky", 32'(o_overflow), 1);
        applyStimulus(0, 1, 0, 4'b0000, 8'h00);
        checkOutput("reopen_ovf_clear", 32'(o_overflow), 0);
        checkOutput("reopen_state2", 32'(o_state), 1);

        // Close beats a simultaneous booth 1 request
        applyStimulus(0, 0, 1, 4'b0010, 8'b00_00_01_00);
        checkOutput("close_no_ack", 32'(o_booth_ack), 0);
        checkOutput("close_drain", 32'(o_state), 2);
        applyStimulus(0, 0, 0, 4'b0010, 8'b00_00_01_00);
        checkOutput("drain_no_ack", 32'(o_booth_ack), 0);
        checkOutput("close_tallies", 32'(o_count), 0);
        applyStimulus(0, 0, 0, 4'b0010, 8'b00_00_01_00);
        checkOutput("result_no_ack", 32'(o_booth_ack), 0);

        // Reset mid-session drops the in-flight ack
        applyStimulus(0, 1, 0, 4'b0000, 8'h00);
        applyStimulus(0, 0, 0, 4'b0001, 8'b00_00_00_01);
        checkOutput("pre_rst_ack", 32'(o_booth_ack), 4'b0001);
        applyStimulus(1, 0, 0, 4'b0010, 8'b00_00_01_01);
        checkOutput("rst_state", 32'(o_state), 0);
        checkOutput("rst_ack", 32'(o_booth_ack), 0);
        checkOutput("rst_invalid", 32'(o_invalid), 0);
        checkOutput("rst_valid", 32'(o_result_valid), 0);
        checkOutput("rst_count", 32'(o_count), 0);
        applyStimulus(0, 0, 0, 4'b0010, 8'h00);
        checkOutput("idle_no_ack", 32'(o_booth_ack), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
